vga_pattern_gen: RTL
====================

Name: vga_pattern_gen

Overview:
- Pixel source stage directly downstream of the VGA timing generator.
- Consumes the raw hcount/vcount counters and the registered sync outputs from the timing generator, and produces a 12-bit 4:4:4 RGB pixel stream.
- hs_out/vs_out are delayed so they stay cycle-aligned with the RGB.
- Test patterns are selectable; the selection takes effect only at frame boundaries, so a frame never tears.

Parameters:
- HSYNC_BITS, 11, width of hcount
- VSYNC_BITS, 11, width of vcount
- HD, 1280, active pixels per line
- VD, 1024, active lines per frame
- H_ORIGIN, 360, hcount of the first active pixel (HR+HB)
- V_ORIGIN, 41, vcount of the first active line (VR+VB)
- HMAX, 1687, last hcount value of a line
- VMAX, 1065, last vcount value of a frame
- BAR_W, 160, pixels per colour bar (HD/8)
- CHK_LOG2, 5, checker square size is 2^CHK_LOG2 pixels

Ports:
- clk  in  1  pixel clock
- arstn  in  1  reset; synchronous, active-low
- hcount  in  HSYNC_BITS  horizontal counter from the timing generator
- vcount  in  VSYNC_BITS  vertical counter from the timing generator
- hs_in  in  1  hsync, sampled in the same cycle as hcount
- vs_in  in  1  vsync, sampled in the same cycle as vcount
- mode_sel  in  3  requested pattern
- color  in  12  user colour, {R[3:0],G[3:0],B[3:0]}
- rgb_out  out  12  pixel colour
- hs_out  out  1  hs_in delayed by 2 cycles
- vs_out  out  1  vs_in delayed by 2 cycles
- de_out  out  1  active-area flag aligned with rgb_out
- frame_cnt  out  16  count of completed frames

Behaviour:
- Reset: arstn is sampled only on the rising edge of clk; it is synchronous and active-low. While arstn=0 at an edge:
  - rgb_out, hs_out, vs_out, de_out and frame_cnt are all 0.
  - mode_q=0, line_pos=0, bar_idx=0, bar_pix=0.
  - All pipeline registers are cleared.
- Reset mid-frame: outputs are 0 on the next edge. After release, operation resumes at whatever counters arrive; the first partial frame uses mode 0.
- Pipeline, fixed latency 2:
  - Stage 1 registers x=hcount-H_ORIGIN, y=vcount-V_ORIGIN, the active flag, and the hs/vs delay.
  - active = (H_ORIGIN <= hcount < H_ORIGIN+HD) && (V_ORIGIN <= vcount < V_ORIGIN+VD).
  - Stage 2 registers rgb_out and de_out, and the second hs/vs delay.
  - rgb_out=0 whenever stage-2 active=0.
- Frame boundary: the cycle with hcount==HMAX && vcount==VMAX. In that cycle:
  - mode_q<=mode_sel.
  - frame_cnt<=frame_cnt+1, wrapping 0xFFFF->0.
  - line_pos<=line_pos+1, wrapping from HD-1 to 0.
  - mode_sel changes at any other time have no visible effect until the next boundary.
- Patterns, evaluated on stage-1 x/y with mode_q:
  - mode 0, solid: color.
  - mode 1, colour bars:
    - bar_pix/bar_idx are cleared on every stage-1 inactive cycle.
    - On active cycles, bar_pix increments. At BAR_W-1, bar_pix wraps to 0 and bar_idx increments; bar_idx saturates at 7.
    - bar_idx 0..7 maps to FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
    - No divider is used.
  - mode 2, checkerboard: color if x[CHK_LOG2]^y[CHK_LOG2]=1, else 000.
  - mode 3, moving line: FFF if x==line_pos, else 000.
  - modes 4-7: 000.
- Width rules:
  - x and y are HSYNC_BITS/VSYNC_BITS unsigned; they are used only when active=1, so underflow is irrelevant.
  - line_pos is HSYNC_BITS wide.
- Simultaneous events: if the frame boundary and reset coincide, reset wins.

Optional Feature:
- Macro: VGA_PATTERN_BORDER_EN.
- Defined: a 1-pixel white (FFF) border overrides every pattern, including modes 4-7, where x==0, x==HD-1, y==0 or y==VD-1.
- Not defined: no border logic is present; patterns are drawn unchanged to the edges.

Test Plan:
- Reset: hold arstn=0 for 5 clocks while counters run -> rgb_out=0, hs_out=0, vs_out=0, de_out=0, frame_cnt=0 throughout.
- Latency/alignment: mode 0, color=0xA5C. Drive hcount=H_ORIGIN, vcount=V_ORIGIN at cycle N -> rgb_out=0xA5C and de_out=1 at N+2. A hs_in pulse shows on hs_out exactly 2 cycles later.
- Colour bars: mode 1 latched, one active line -> rgb_out is FFF for x=0..159, FF0 for x=160..319, and so on, with 000 for x=1120..1279. rgb_out=0 in blanking.
- Frame-boundary mode latch: set mode_sel=2 mid-frame -> the current frame keeps mode 0. The next frame is a checkerboard: x=0..31,y=0 gives 000; x=32,y=0 gives color; x=32,y=32 gives 000.
- Moving line and wraps: mode 3 -> frame k shows FFF only at x==k mod 1280. After 1280 frames, line_pos is back at 0. Preload frame_cnt to 0xFFFF via running the bench -> it wraps to 0x0000.
- VGA_PATTERN_BORDER_EN defined, mode 4 -> FFF at (0,y), (1279,y), (x,0), (x,1023); 000 elsewhere. Not defined -> 000 everywhere.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: two-stage pixel source fed by the VGA timing counters.
// Define VGA_PATTERN_BORDER_EN to overlay a 1-pixel white border on every pattern.

module vga_pattern_gen #(
  parameter int HSYNC_BITS = 11,
  parameter int VSYNC_BITS = 11,
  parameter int HD         = 1280,
  parameter int VD         = 1024,
  parameter int H_ORIGIN   = 360,
  parameter int V_ORIGIN   = 41,
  parameter int HMAX       = 1687,
  parameter int VMAX       = 1065,
  parameter int BAR_W      = 160,
  parameter int CHK_LOG2   = 5
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [HSYNC_BITS-1:0] hcount,
  input  logic [VSYNC_BITS-1:0] vcount,
  input  logic                  hs_in,
  input  logic                  vs_in,
  input  logic [2:0]            mode_sel,
  input  logic [11:0]           color,
  output logic [11:0]           rgb_out,
  output logic                  hs_out,
  output logic                  vs_out,
  output logic                  de_out,
  output logic [15:0]           frame_cnt
);

  localparam int BAR_BITS = $clog2(BAR_W);

  localparam logic [HSYNC_BITS-1:0] H_FIRST = HSYNC_BITS'(H_ORIGIN);
  localparam logic [HSYNC_BITS-1:0] H_STOP  = HSYNC_BITS'(H_ORIGIN + HD);
  localparam logic [HSYNC_BITS-1:0] H_LAST  = HSYNC_BITS'(HMAX);
  localparam logic [HSYNC_BITS-1:0] X_LAST  = HSYNC_BITS'(HD - 1);
  localparam logic [VSYNC_BITS-1:0] V_FIRST = VSYNC_BITS'(V_ORIGIN);
  localparam logic [VSYNC_BITS-1:0] V_STOP  = VSYNC_BITS'(V_ORIGIN + VD);
  localparam logic [VSYNC_BITS-1:0] V_LAST  = VSYNC_BITS'(VMAX);
  localparam logic [BAR_BITS-1:0]   BAR_LAST = BAR_BITS'(BAR_W - 1);

  localparam logic [2:0]  MODE_SOLID = 3'd0;
  localparam logic [2:0]  MODE_BARS  = 3'd1;
  localparam logic [2:0]  MODE_CHECK = 3'd2;
  localparam logic [2:0]  MODE_LINE  = 3'd3;
  localparam logic [11:0] WHITE      = 12'hFFF;
  localparam logic [11:0] BLACK      = 12'h000;

  logic                  active_in;
  logic                  frame_end;
  logic [HSYNC_BITS-1:0] x1;
  logic                  y_chk;
  logic                  act1;
  logic                  hs1;
  logic                  vs1;
  logic [2:0]            mode_q;
  logic [HSYNC_BITS-1:0] line_pos;
  logic [2:0]            bar_idx;
  logic [BAR_BITS-1:0]   bar_pix;
  logic [11:0]           bar_rgb;
  logic [11:0]           pix;

`ifdef VGA_PATTERN_BORDER_EN
  localparam logic [VSYNC_BITS-1:0] Y_LAST = VSYNC_BITS'(VD - 1);
  logic [VSYNC_BITS-1:0] y1;
`endif

  assign active_in = (hcount >= H_FIRST) && (hcount < H_STOP) &&
                     (vcount >= V_FIRST) && (vcount < V_STOP);
  assign frame_end = (hcount == H_LAST) && (vcount == V_LAST);

  // Stage 1: origin-relative coordinates; only the checker bit of y is needed without the border.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      x1    <= '0;
      y_chk <= 1'b0;
      act1  <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
`ifdef VGA_PATTERN_BORDER_EN
      y1    <= '0;
`endif
    end else begin
      x1    <= hcount - H_FIRST;
      y_chk <= 1'((vcount - V_FIRST) >> CHK_LOG2);
      act1  <= active_in;
      hs1   <= hs_in;
      vs1   <= vs_in;
`ifdef VGA_PATTERN_BORDER_EN
      y1    <= vcount - V_FIRST;
`endif
    end
  end

  // Mode, frame counter and moving-line position only advance at the frame boundary.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      mode_q    <= MODE_SOLID;
      frame_cnt <= 16'd0;
      line_pos  <= '0;
    end else if (frame_end) begin
      mode_q    <= mode_sel;
      frame_cnt <= frame_cnt + 16'd1;
      line_pos  <= (line_pos == X_LAST) ? '0 : line_pos + 1'b1;
    end
  end

  // Bar position tracks the stage-1 pixel by counting, so no divide by BAR_W is needed.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      bar_pix <= '0;
      bar_idx <= 3'd0;
    end else if (!act1) begin
      bar_pix <= '0;
      bar_idx <= 3'd0;
    end else if (bar_pix == BAR_LAST) begin
      bar_pix <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pix <= bar_pix + 1'b1;
    end
  end

  always_comb begin
    bar_rgb = BLACK;
    case (bar_idx)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = BLACK;
    endcase
  end

  always_comb begin
    pix = BLACK;
    case (mode_q)
      MODE_SOLID: pix = color;
      MODE_BARS:  pix = bar_rgb;
      MODE_CHECK: pix = (x1[CHK_LOG2] ^ y_chk) ? color : BLACK;
      MODE_LINE:  pix = (x1 == line_pos) ? WHITE : BLACK;
      default:    pix = BLACK;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if ((x1 == '0) || (x1 == X_LAST) || (y1 == '0) || (y1 == Y_LAST)) pix = WHITE;
`endif
  end

  // Stage 2: blanking forces black so downstream never sees stale pattern data.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      rgb_out <= BLACK;
      de_out  <= 1'b0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
    end else begin
      rgb_out <= act1 ? pix : BLACK;
      de_out  <= act1;
      hs_out  <= hs1;
      vs_out  <= vs1;
    end
  end

endmodule
